// File: rtl/uart_bench_pkg.sv
// Shared definitions for the bench-side UART transmitter: FSM encoding,
// parity mode constants and the parity helper.
package uart_bench_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Parity bit for one data byte; no-parity mode never puts this on the line.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    case (mode)
      PAR_ODD:  return ~^data;
      PAR_EVEN: return ^data;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bench_sync_fifo.sv
// Single-clock byte FIFO with occupancy count. The head entry is visible
// combinationally so the transmitter can pop and load in the same edge.
module bench_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // A push is judged against the pre-edge full flag, so a pop on the same
  // edge never rescues a write into a full FIFO.
  assign w_push  = wr_en && !full;
  assign w_pop   = rd_en && !empty;
  assign full    = (r_count == FULL_COUNT);
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; reset flushes and wins over any same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_bench_tx.sv
// Bench-side UART transmitter: bytes queued in a FIFO are serialised as
// start + 8 data (LSB first) + optional parity + 1/2 stop bits.
module uart_bench_tx
  import uart_bench_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic                          overflow,
  output logic                          tx
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit_idx;
  logic          r_stop_idx;
  logic [7:0]    r_data;
  logic          r_tx;
  logic          r_busy;
  logic          r_overflow;
  logic          w_pop;
  logic          w_bit_done;
  logic          w_stop_last;
  logic          w_tx_bit;
  logic [7:0]    w_fifo_data;
  logic          w_empty;
  logic          w_full;

  bench_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (w_pop),
    .rd_data (w_fifo_data),
    .full    (w_full),
    .empty   (w_empty),
    .count   (count)
  );

  assign w_bit_done  = (r_baud == '0);
  assign w_stop_last = (STOP_BITS == 1) ? 1'b1 : r_stop_idx;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; the pop is issued on the transition into START so the
  // head byte lands in the data register on that same edge.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_done) w_state_next = ST_DATA;
      end
      ST_DATA: begin
        if (w_bit_done && (r_bit_idx == 3'd7)) begin
          w_state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (w_bit_done) w_state_next = ST_STOP;
      end
      ST_STOP: begin
        if (w_bit_done && w_stop_last) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_state_next = ST_START;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Line level for the current state; registered below so tx never glitches.
  always_comb begin
    w_tx_bit = 1'b1;
    case (r_state)
      ST_START:  w_tx_bit = 1'b0;
      ST_DATA:   w_tx_bit = r_data[r_bit_idx];
      ST_PARITY: w_tx_bit = parity_bit(r_data, PARITY);
      default:   w_tx_bit = 1'b1;
    endcase
  end

  // Baud counter, bit/stop indices and the frame data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud     <= BAUD_LOAD;
      r_bit_idx  <= 3'd0;
      r_stop_idx <= 1'b0;
      r_data     <= 8'h00;
    end else begin
      if (r_state == ST_IDLE || w_bit_done) r_baud <= BAUD_LOAD;
      else                                  r_baud <= r_baud - 1'b1;

      if (r_state != ST_DATA) r_bit_idx <= 3'd0;
      else if (w_bit_done)    r_bit_idx <= r_bit_idx + 1'b1;

      if (r_state != ST_STOP) r_stop_idx <= 1'b0;
      else if (w_bit_done)    r_stop_idx <= ~r_stop_idx;

      if (w_pop) r_data <= w_fifo_data;
    end
  end

  // Registered line, busy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_tx   <= w_tx_bit;
      r_busy <= (r_state != ST_IDLE);
      if (wr_en && w_full) r_overflow <= 1'b1;
    end
  end

  assign tx       = r_tx;
  assign busy     = r_busy;
  assign overflow = r_overflow;
  assign full     = w_full;
  assign empty    = w_empty;

endmodule
